// File: rtl/st_fifo_pkg.sv
// Shared definitions for the Avalon-ST sink FIFO path.
// Word layout, bit positions and framing FSM encodings.
package st_fifo_pkg;

    localparam int ST_SOP_BIT   = 18;
    localparam int ST_EOP_BIT   = 17;
    localparam int ST_TRUNC_BIT = 16;
    localparam int ST_WORD_W    = 19;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } st_state_e;

    function automatic logic [ST_WORD_W-1:0] st_pack(
        input logic        sop,
        input logic        eop,
        input logic        trunc,
        input logic [15:0] data
    );
        return {sop, eop, trunc, data};
    endfunction

endpackage

// File: rtl/sink_st_fifo.sv
// Single-clock RAM FIFO holding framed ST words.
// Registered read port; full/empty guarded internally.
module sink_st_fifo
    import st_fifo_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wrreq,
    input  logic [ST_WORD_W-1:0] data,
    input  logic                 rdreq,
    output logic [ST_WORD_W-1:0] q,
    output logic                 empty,
    output logic [AW:0]          usedw
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [ST_WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]        wrptr;
    logic [AW-1:0]        rdptr;
    logic [AW:0]          count;
    logic                 do_wr;
    logic                 do_rd;

    assign do_wr = wrreq && (count != FULL_CNT);
    assign do_rd = rdreq && (count != '0);

    // RAM array kept free of reset so it maps onto block memory
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wrptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr <= '0;
            rdptr <= '0;
            count <= '0;
            q     <= '0;
        end else begin
            if (do_wr) begin
                wrptr <= wrptr + 1'b1;
            end
            if (do_rd) begin
                rdptr <= rdptr + 1'b1;
                q     <= mem[rdptr];
            end
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign empty = (count == '0);
    assign usedw = count;

endmodule

// File: rtl/st_2_fifo.sv
// Avalon-ST sink: checks SOP/EOP framing and buffers beats
// as {sop, eop, trunc, data} words for the SDRAM write side.
module st_2_fifo
    import st_fifo_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 st_sink_valid,
    input  logic                 st_sink_sop,
    input  logic                 st_sink_eop,
    input  logic [15:0]          st_sink_data,
    output logic                 st_sink_ready,
    input  logic                 sink_fifo_rdreq,
    output logic [ST_WORD_W-1:0] sink_fifo_data,
    output logic                 sink_fifo_empty,
    output logic [AW:0]          sink_fifo_rdusedw,
    output logic [15:0]          trunc_cnt
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    st_state_e            state;
    st_state_e            state_nxt;
    logic                 accept;
    logic                 wr_en;
    logic                 trunc;
    logic [ST_WORD_W-1:0] wr_word;

    // Ready depends only on the registered count, never on rdreq
    assign st_sink_ready = (sink_fifo_rdusedw != FULL_CNT);
    assign accept        = st_sink_valid && st_sink_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        trunc     = 1'b0;
        if (accept) begin
            unique case (state)
                ST_IDLE: begin
                    if (st_sink_sop) begin
                        wr_en     = 1'b1;
                        state_nxt = st_sink_eop ? ST_IDLE : ST_IN_PKT;
                    end
                end
                ST_IN_PKT: begin
                    wr_en     = 1'b1;
                    trunc     = st_sink_sop;
                    state_nxt = st_sink_eop ? ST_IDLE : ST_IN_PKT;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign wr_word = st_pack(st_sink_sop, st_sink_eop, trunc, st_sink_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            trunc_cnt <= '0;
        end else if (trunc && (trunc_cnt != 16'hFFFF)) begin
            trunc_cnt <= trunc_cnt + 1'b1;
        end
    end

    sink_st_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wrreq (wr_en),
        .data  (wr_word),
        .rdreq (sink_fifo_rdreq),
        .q     (sink_fifo_data),
        .empty (sink_fifo_empty),
        .usedw (sink_fifo_rdusedw)
    );

endmodule

// File: tb/tb_st_2_fifo.sv
// Directed bench for st_2_fifo with a scoreboard queue of expected words.
// Beats are predicted from the framing rules and compared on readout.
module tb_st_2_fifo;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          st_sink_valid = 1'b0;
    logic          st_sink_sop = 1'b0;
    logic          st_sink_eop = 1'b0;
    logic [15:0]   st_sink_data = '0;
    logic          st_sink_ready;
    logic          sink_fifo_rdreq = 1'b0;
    logic [18:0]   sink_fifo_data;
    logic          sink_fifo_empty;
    logic [AW:0]   sink_fifo_rdusedw;
    logic [15:0]   trunc_cnt;

    int            errors = 0;
    int            checks = 0;
    logic [18:0]   sb[$];
    logic          m_in_pkt = 1'b0;
    logic [15:0]   m_trunc = '0;
    logic [18:0]   last_q;

    always #5 clk = ~clk;

    st_2_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .st_sink_valid     (st_sink_valid),
        .st_sink_sop       (st_sink_sop),
        .st_sink_eop       (st_sink_eop),
        .st_sink_data      (st_sink_data),
        .st_sink_ready     (st_sink_ready),
        .sink_fifo_rdreq   (sink_fifo_rdreq),
        .sink_fifo_data    (sink_fifo_data),
        .sink_fifo_empty   (sink_fifo_empty),
        .sink_fifo_rdusedw (sink_fifo_rdusedw),
        .trunc_cnt         (trunc_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Predict the stored word for an accepted beat
    task automatic model(input logic sop, input logic eop,
                         input logic [15:0] d);
        if (!m_in_pkt) begin
            if (sop) begin
                sb.push_back({sop, eop, 1'b0, d});
                m_in_pkt = !eop;
            end
        end else begin
            sb.push_back({sop, eop, sop, d});
            if (sop && m_trunc != 16'hFFFF) m_trunc++;
            m_in_pkt = !eop;
        end
    endtask

    task automatic send(input logic sop, input logic eop,
                        input logic [15:0] d, input string tag);
        st_sink_valid = 1'b1;
        st_sink_sop   = sop;
        st_sink_eop   = eop;
        st_sink_data  = d;
        chk({tag, "_ready"}, 32'(st_sink_ready), 32'd1);
        @(posedge clk);
        #1;
        model(sop, eop, d);
        st_sink_valid = 1'b0;
        st_sink_sop   = 1'b0;
        st_sink_eop   = 1'b0;
    endtask

    task automatic rd(input string tag);
        logic [18:0] e;
        sink_fifo_rdreq = 1'b1;
        @(posedge clk);
        #1;
        sink_fifo_rdreq = 1'b0;
        if (sb.size() == 0) begin
            chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk(tag, 32'(sink_fifo_data), 32'(e));
        end
        last_q = sink_fifo_data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_in_pkt = 1'b0;
        m_trunc  = '0;
    endtask

    initial begin
        // 1: reset state and a 4-beat packet
        rst = 1'b1;
        @(posedge clk);
        do_reset();
        chk("rst_usedw", 32'(sink_fifo_rdusedw), 32'd0);
        chk("rst_empty", 32'(sink_fifo_empty), 32'd1);
        chk("rst_data", 32'(sink_fifo_data), 32'd0);
        chk("rst_trunc", 32'(trunc_cnt), 32'd0);
        chk("rst_ready", 32'(st_sink_ready), 32'd1);
        send(1'b1, 1'b0, 16'h0001, "p1_b1");
        send(1'b0, 1'b0, 16'h0002, "p1_b2");
        send(1'b0, 1'b0, 16'h0003, "p1_b3");
        send(1'b0, 1'b1, 16'h0004, "p1_b4");
        chk("p1_usedw", 32'(sink_fifo_rdusedw), 32'd4);
        chk("p1_sb_w0", 32'(sb[0]), 32'h40001);
        chk("p1_sb_w3", 32'(sb[3]), 32'h20004);
        for (int i = 0; i < 4; i++) rd("p1_rd");
        chk("p1_empty", 32'(sink_fifo_empty), 32'd1);

        // 2: orphan beat while idle is accepted and dropped
        send(1'b0, 1'b0, 16'hBEEF, "orphan");
        chk("orphan_usedw", 32'(sink_fifo_rdusedw), 32'd0);
        chk("orphan_empty", 32'(sink_fifo_empty), 32'd1);

        // 3: truncated packet
        send(1'b1, 1'b0, 16'h0010, "tr_b1");
        send(1'b0, 1'b0, 16'h0011, "tr_b2");
        send(1'b1, 1'b0, 16'h0020, "tr_b3");
        chk("tr_trunc_cnt", 32'(trunc_cnt), 32'd1);
        chk("tr_sb_w2", 32'(sb[2]), 32'h50020);
        for (int i = 0; i < 3; i++) rd("tr_rd");

        // 4: fill to full from pointer 0, then free one slot
        do_reset();
        send(1'b1, 1'b0, 16'h1000, "fill");
        for (int i = 1; i < DEPTH; i++) begin
            send(1'b0, 1'b0, 16'(16'h1000 + i), "fill");
        end
        chk("full_usedw", 32'(sink_fifo_rdusedw), 32'(DEPTH));
        chk("full_ready", 32'(st_sink_ready), 32'd0);
        st_sink_valid   = 1'b1;
        st_sink_data    = 16'hCAFE;
        sink_fifo_rdreq = 1'b1;
        @(posedge clk);
        #1;
        sink_fifo_rdreq = 1'b0;
        chk("full_rd", 32'(sink_fifo_data), 32'(sb.pop_front()));
        chk("freed_ready", 32'(st_sink_ready), 32'd1);
        chk("freed_usedw", 32'(sink_fifo_rdusedw), 32'(DEPTH - 1));
        @(posedge clk);
        #1;
        model(1'b0, 1'b0, 16'hCAFE);
        st_sink_valid = 1'b0;
        chk("wrap_usedw", 32'(sink_fifo_rdusedw), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) rd("drain");
        chk("drain_last", 32'(last_q), 32'h0CAFE);
        chk("drain_empty", 32'(sink_fifo_empty), 32'd1);

        // 5: simultaneous write and read at usedw=5
        for (int i = 0; i < 5; i++) send(1'b0, 1'b0, 16'(16'h0500 + i), "wr5");
        chk("wr5_usedw", 32'(sink_fifo_rdusedw), 32'd5);
        st_sink_valid   = 1'b1;
        st_sink_data    = 16'h0555;
        sink_fifo_rdreq = 1'b1;
        @(posedge clk);
        #1;
        st_sink_valid   = 1'b0;
        sink_fifo_rdreq = 1'b0;
        chk("wr_rd_data", 32'(sink_fifo_data), 32'(sb.pop_front()));
        model(1'b0, 1'b0, 16'h0555);
        chk("wr_rd_usedw", 32'(sink_fifo_rdusedw), 32'd5);
        for (int i = 0; i < 5; i++) rd("wr5_rd");
        sink_fifo_rdreq = 1'b1;
        @(posedge clk);
        #1;
        sink_fifo_rdreq = 1'b0;
        chk("empty_rd_hold", 32'(sink_fifo_data), 32'(last_q));
        chk("empty_rd_usedw", 32'(sink_fifo_rdusedw), 32'd0);

        // 6: reset mid-packet
        send(1'b1, 1'b1, 16'h0600, "p6_close");
        void'(sb.pop_back());
        do_reset();
        send(1'b1, 1'b0, 16'h0601, "p6");
        send(1'b0, 1'b0, 16'h0602, "p6");
        send(1'b1, 1'b0, 16'h0603, "p6");
        for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 16'(16'h0610 + i), "p6");
        chk("p6_usedw", 32'(sink_fifo_rdusedw), 32'd7);
        chk("p6_trunc", 32'(trunc_cnt), 32'(m_trunc));
        do_reset();
        chk("mid_rst_usedw", 32'(sink_fifo_rdusedw), 32'd0);
        chk("mid_rst_empty", 32'(sink_fifo_empty), 32'd1);
        chk("mid_rst_data", 32'(sink_fifo_data), 32'd0);
        chk("mid_rst_trunc", 32'(trunc_cnt), 32'd0);
        send(1'b0, 1'b0, 16'h0777, "post_rst");
        chk("post_rst_usedw", 32'(sink_fifo_rdusedw), 32'd0);
        chk("post_rst_empty", 32'(sink_fifo_empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
